// File: rtl/comparador_serial_arbitrado.sv
// comparador_serial_arbitrado
//   One bit-serial magnitude comparator shared by two requesters through a
//   round-robin arbiter. The granted operands are latched and scanned
//   MSB-first, one bit per clock, stopping at the first differing bit.
//
// Ports
//   clock, reset      : clock, synchronous active-high reset
//   req0, a0, b0      : requester 0 request level and operands
//   req1, a1, b1      : requester 1 request level and operands
//   ack0, ack1        : one-cycle grant pulse (first COMPARA cycle)
//   busy              : transaction in progress (state != IDLE)
//   done              : one-cycle result-valid pulse (FIM state)
//   done_id           : owner of the current/last result
//   IG, MA, ME        : A==B, A>B, A<B of the last completed transaction
//   ciclos            : bit steps used by the last completed transaction
module comparador_serial_arbitrado #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             IG,
  output logic             MA,
  output logic             ME,
  output logic [CW-1:0]    ciclos
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COMPARA, S_FIM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             ultimo_q, ultimo_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             ig_q, ig_d, ma_q, ma_d, me_q, me_d;
  logic [CW-1:0]    ciclos_q, ciclos_d;
  logic             done_id_q, done_id_d;

  logic             gnt1;
  logic             bit_a, bit_b;
  logic [CW-1:0]    steps;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      ultimo_q  <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      ig_q      <= 1'b0;
      ma_q      <= 1'b0;
      me_q      <= 1'b0;
      ciclos_q  <= '0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      ultimo_q  <= ultimo_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      ig_q      <= ig_d;
      ma_q      <= ma_d;
      me_q      <= me_d;
      ciclos_q  <= ciclos_d;
      done_id_q <= done_id_d;
    end
  end

  // Requester 1 wins when it is alone, or on a tie when 0 was served last.
  assign gnt1  = req1 & (~req0 | ~ultimo_q);
  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];
  assign steps = cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    ultimo_d  = ultimo_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    ig_d      = ig_q;
    ma_d      = ma_q;
    me_d      = me_q;
    ciclos_d  = ciclos_q;
    done_id_d = done_id_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          a_d      = gnt1 ? a1 : a0;
          b_d      = gnt1 ? b1 : b0;
          owner_d  = gnt1;
          ultimo_d = gnt1;
          idx_d    = IW'(WIDTH-1);
          cnt_d    = '0;
          ack0_d   = ~gnt1;
          ack1_d   = gnt1;
          state_d  = S_COMPARA;
        end
      end
      S_COMPARA: begin
        cnt_d = steps;
        // First differing bit from the top decides; equal all the way down is IG.
        if (bit_a != bit_b || idx_q == '0) begin
          ig_d      = (bit_a == bit_b);
          ma_d      = bit_a & ~bit_b;
          me_d      = ~bit_a & bit_b;
          ciclos_d  = steps;
          done_id_d = owner_q;
          state_d   = S_FIM;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_FIM:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FIM);
  assign done_id = done_id_q;
  assign IG      = ig_q;
  assign MA      = ma_q;
  assign ME      = me_q;
  assign ciclos  = ciclos_q;

endmodule

// File: doc/comparador_serial_arbitrado.md
# comparador_serial_arbitrado

Shared, sequential magnitude comparator serving two requesters. Operands from the granted requester are latched and compared MSB-first, one bit per clock, using the enable-chained 1-bit equal/greater/less cell behaviour, with early termination at the first differing bit. It sits between two operand sources (e.g. switch banks or upstream FSMs) and the LED/status logic. It replaces two parallel comparators with one bit-serial datapath plus a round-robin arbiter.

## Interface
- WIDTH, 4, operand width in bits (≥1)
- CW, $clog2(WIDTH+1), width of `ciclos` (derived, not overridden)

- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0  in  1  requester 0 request level
- a0, b0  in  WIDTH each  requester 0 operands A, B
- req1  in  1  requester 1 request level
- a1, b1  in  WIDTH each  requester 1 operands A, B
- ack0, ack1  out  1 each  one-cycle grant pulse; operands latched
- busy  out  1  transaction in progress (state ≠ IDLE)
- done  out  1  one-cycle result-valid pulse
- done_id  out  1  requester that owns the current/last result
- IG, MA, ME  out  1 each  A==B, A>B, A<B for the last completed transaction
- ciclos  out  CW  bit steps used by the last completed transaction (1..WIDTH)

## Operation
- FSM states: IDLE, COMPARA, FIM.
- IDLE: requests sampled only here. If neither req is high, stay. If exactly one is high, grant it. If both are high, grant the one not served last. `ultimo` register, reset = 1, so requester 0 wins the first tie.
- On grant: latch the granted a/b into internal A_r/B_r; owner ← id; ultimo ← id; idx ← WIDTH-1; cnt ← 0; go COMPARA. The matching ack is high during the first COMPARA cycle only.
- COMPARA, each cycle: cnt+1 is the step count.
  - A_r[idx]=1, B_r[idx]=0 → MA=1, IG=0, ME=0, go FIM.
  - A_r[idx]=0, B_r[idx]=1 → ME=1, IG=0, MA=0, go FIM.
  - Bits equal and idx=0 → IG=1, MA=0, ME=0, go FIM.
  - Bits equal and idx>0 → idx ← idx-1, stay.
- On entry to FIM: ciclos ← steps and done_id ← owner, registered together with IG/MA/ME.
- FIM: done=1 for exactly this cycle; go IDLE unconditionally.
- Exactly one of IG/MA/ME is 1 after the first completed transaction. Results are held until the next entry into FIM.
- Operand or req changes after the grant edge are ignored. A requester must drop req in the cycle it sees ack; req still high when FIM→IDLE completes is a new request.
- ack0 and ack1 are never high together. done and ack are never high together.
- WIDTH=1: a single COMPARA cycle; ciclos=1.

## Timing
- Reset values: ack0=ack1=busy=done=done_id=IG=MA=ME=0, ciclos=0, state=IDLE, ultimo=1.
- Reset has priority in every state. Asserted mid-COMPARA or in FIM, it aborts the transaction: no done, results return to 0, IDLE on the next cycle.
- Edge E0 (IDLE, req seen): cycle after E0 has busy=1 and ack=1.
- Steps n = WIDTH-p, where p is the index of the most-significant differing bit; n = WIDTH if the operands are equal.
- The edge En enters FIM, so done is high in the cycle after En.
- E(n+1) returns to IDLE with busy=0. The earliest next grant edge is E(n+2).
- Throughput: one transaction per n+2 cycles.

## Test plan
- Reset, then apply no requests for 10 cycles → all outputs 0, busy=0, no ack/done pulses.
- req0 with a0=4'hA, b0=4'h3 → ack0 for 1 cycle; done 1 cycle later; MA=1, IG=ME=0, ciclos=1, done_id=0.
- req1 with a1=4'h5, b1=4'h5 → ack1; done 4 cycles after ack; IG=1, ciclos=4, done_id=1.
- req0 with a0=4'b0110, b0=4'b0111 → ME=1, ciclos=4. Change a0 to 4'hF the cycle after ack → result unchanged.
- req0 and req1 both held high continuously from reset release → grants in order 0,1,0,1. No cycle with both acks high. Each grant follows the previous done by exactly 1 idle cycle.
- req0 with a0=4'h0, b0=4'h1; assert reset for 1 cycle during the 2nd COMPARA cycle → no done pulse; next cycle IDLE with outputs at reset values. A fresh req1 is then granted first (ultimo reset to 1).
